// File: rtl/wi_line_buffer.sv
// Buffers 64 B MRA response lines and emits them as two work items each (lower half first).
// Optional stall counter output enabled by the WI_STALL_CNT_EN macro.
module wi_line_buffer #(
    parameter int LINE_WIDTH  = 512,
    parameter int WI_WIDTH    = 256,
    parameter int DEPTH       = 20,
    parameter int WL_LEN_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_dispatch,
    input  logic [WL_LEN_BITS-1:0] WL_len,
    input  logic [LINE_WIDTH-1:0]  MRA_resp_data,
    input  logic                   MRA_resp_valid,
    output logic                   MRA_resp_ready,
    output logic [WI_WIDTH-1:0]    WI_data,
    output logic                   WI_valid,
    input  logic                   WI_ready,
    output logic                   FIFO_rd_en,
    output logic                   wl_done,
`ifdef WI_STALL_CNT_EN
    output logic [31:0]            stall_cycles,
`endif
    output logic                   resp_overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t                 state_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   half_sel_q;
    logic [WL_LEN_BITS-1:0] items_remain_q;
    logic                   wl_done_q;
    logic                   overflow_q;
    logic [LINE_WIDTH-1:0]  mem [DEPTH];

    logic                   active, push, accept, last_item, pop;
    logic [LINE_WIDTH-1:0]  head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign active         = (state_q == ACTIVE);
    assign MRA_resp_ready = active && (count_q != DEPTH_C);
    assign WI_valid       = active && (count_q != '0);
    assign push           = MRA_resp_valid && MRA_resp_ready;
    assign accept         = WI_valid && WI_ready;
    assign last_item      = (items_remain_q == WL_LEN_BITS'(1));
    // An odd-length list retires its final line on the lower half; the upper half is dropped.
    assign pop            = accept && (half_sel_q || last_item);
    assign head           = mem[rd_ptr_q];

    assign WI_data       = !WI_valid   ? '0 :
                           half_sel_q  ? head[LINE_WIDTH-1:WI_WIDTH] : head[WI_WIDTH-1:0];
    assign FIFO_rd_en    = pop;
    assign wl_done       = wl_done_q;
    assign resp_overflow = overflow_q;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= MRA_resp_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            half_sel_q     <= 1'b0;
            items_remain_q <= '0;
            wl_done_q      <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wl_done_q  <= 1'b0;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Ready low means full or not ACTIVE, so any dropped valid is an overflow.
            if (MRA_resp_valid && !MRA_resp_ready) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start_dispatch) begin
                        items_remain_q <= WL_len;
                        half_sel_q     <= 1'b0;
                        wr_ptr_q       <= '0;
                        rd_ptr_q       <= '0;
                        count_q        <= '0;
                        if (WL_len == '0) begin
                            state_q   <= DONE;
                            wl_done_q <= 1'b1;
                        end else begin
                            state_q   <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (items_remain_q != '0) items_remain_q <= items_remain_q - 1'b1;
                        half_sel_q <= !pop;
                        if (last_item) begin
                            state_q   <= DONE;
                            wl_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WI_STALL_CNT_EN
    logic [31:0] stall_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start_dispatch) begin
            stall_q <= '0;
        end else if (WI_valid && !WI_ready && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wi_line_buffer.sv
// Scoreboard bench for wi_line_buffer: expected work items queued at line push, checked on accept.
module tb_wi_line_buffer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_dispatch = 1'b0;
    logic [31:0]  WL_len = '0;
    logic [511:0] MRA_resp_data = '0;
    logic         MRA_resp_valid = 1'b0;
    logic         MRA_resp_ready;
    logic [255:0] WI_data;
    logic         WI_valid;
    logic         WI_ready = 1'b0;
    logic         FIFO_rd_en;
    logic         wl_done;
    logic         resp_overflow;
`ifdef WI_STALL_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    wi_line_buffer dut (
        .clk(clk), .rst_n(rst_n), .start_dispatch(start_dispatch), .WL_len(WL_len),
        .MRA_resp_data(MRA_resp_data), .MRA_resp_valid(MRA_resp_valid),
        .MRA_resp_ready(MRA_resp_ready), .WI_data(WI_data), .WI_valid(WI_valid),
        .WI_ready(WI_ready), .FIFO_rd_en(FIFO_rd_en), .wl_done(wl_done),
`ifdef WI_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .resp_overflow(resp_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic         rd;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     errors = 0, checks = 0;
    int     acc_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int     cyc = 0, acc_cyc = -10, done_cyc = -20;

    always @(posedge clk) cyc++;

    // Scoreboard: every accepted item must match the next expected item and its pop flag.
    always @(negedge clk) begin
        if (rst_n && WI_valid && WI_ready) begin
            acc_cnt++;
            acc_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL item_unexpected got data=%h", WI_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (WI_data !== mon_e.d || FIFO_rd_en !== mon_e.rd) begin
                    errors++;
                    $display("FAIL item got data=%h rd_en=%b expected data=%h rd_en=%b",
                             WI_data, FIFO_rd_en, mon_e.d, mon_e.rd);
                end
            end
        end
        if (FIFO_rd_en) rd_cnt++;
        if (wl_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic logic [511:0] mk_line(input int tag);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = {16'(tag), 16'(i)};
        return l;
    endfunction

    task automatic start(input int unsigned len);
        start_dispatch = 1'b1;
        WL_len = len;
        @(posedge clk); #1;
        start_dispatch = 1'b0;
    endtask

    task automatic push_line(input logic [511:0] d, input int nitems);
        exp_t e;
        bit   ok = 0;
        e.d = d[255:0];   e.rd = (nitems == 1); exp_q.push_back(e);
        if (nitems == 2) begin
            e.d = d[511:256]; e.rd = 1'b1; exp_q.push_back(e);
        end
        MRA_resp_data  = d;
        MRA_resp_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (MRA_resp_ready) ok = 1;
        end
        @(posedge clk); #1;
        MRA_resp_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout ready=%b required=1", MRA_resp_ready);
        end
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        for (int i = 0; i < 500 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout wl_done_count=%0d required=%0d", name, done_cnt, d0 + 1);
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({MRA_resp_ready, WI_valid, FIFO_rd_en, wl_done, resp_overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {MRA_resp_ready, WI_valid, FIFO_rd_en, wl_done, resp_overflow});
        end
        checks++;
        if (WI_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h required=0", WI_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (MRA_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got=%b required=0", MRA_resp_ready);
        end
    endtask

    task automatic test_even_list;
        int r0 = rd_cnt;
        WI_ready = 1'b1;
        start(4);
        push_line(mk_line(16'hA0), 2);
        push_line(mk_line(16'hB0), 2);
        wait_done("even");
        checks++;
        if (rd_cnt - r0 != 2) begin
            errors++;
            $display("FAIL even_rd_en_count got=%0d required=2", rd_cnt - r0);
        end
        checks++;
        if (done_cyc != acc_cyc + 1) begin
            errors++;
            $display("FAIL even_done_timing got_cycle=%0d required=%0d", done_cyc, acc_cyc + 1);
        end
        checks++;
        if (wl_done !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL even_done_width wl_done=%b pending=%0d required 0/0", wl_done, exp_q.size());
        end
    endtask

    task automatic test_odd_list;
        int r0 = rd_cnt;
        WI_ready = 1'b1;
        start(3);
        push_line(mk_line(16'hA1), 2);
        push_line(mk_line(16'hB1), 1);
        wait_done("odd");
        @(negedge clk);
        checks++;
        if (rd_cnt - r0 != 2 || WI_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL odd_end rd_en_count=%0d valid=%b pending=%0d required 2/0/0",
                     rd_cnt - r0, WI_valid, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int r0 = rd_cnt;
        WI_ready = 1'b0;
        start(60);
        for (int i = 0; i < 20; i++) push_line(mk_line(16'h100 + i), 2);
        @(negedge clk);
        checks++;
        if (MRA_resp_ready !== 1'b0 || WI_valid !== 1'b1 || resp_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_state ready=%b valid=%b overflow=%b required 0/1/0",
                     MRA_resp_ready, WI_valid, resp_overflow);
        end
        @(posedge clk); #1;
        MRA_resp_data  = mk_line(16'hDEAD);
        MRA_resp_valid = 1'b1;
        @(posedge clk); #1;
        MRA_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got=%b required=1", resp_overflow);
        end
        @(posedge clk); #1;
        WI_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 20; i < 30; i++) push_line(mk_line(16'h100 + i), 2);
        wait_done("overflow");
        checks++;
        if (rd_cnt - r0 != 30 || resp_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drain rd_en_count=%0d overflow=%b required 30/1",
                     rd_cnt - r0, resp_overflow);
        end
    endtask

    task automatic test_zero_len;
        start(0);
        @(negedge clk);
        checks++;
        if ({wl_done, WI_valid, MRA_resp_ready} !== 3'b100) begin
            errors++;
            $display("FAIL zero_done got done/valid/ready=%b required=100",
                     {wl_done, WI_valid, MRA_resp_ready});
        end
        @(negedge clk);
        checks++;
        if ({wl_done, WI_valid, MRA_resp_ready} !== 3'b000) begin
            errors++;
            $display("FAIL zero_after got done/valid/ready=%b required=000",
                     {wl_done, WI_valid, MRA_resp_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int a0;
        WI_ready = 1'b0;
        start(8);
        push_line(mk_line(16'hA2), 2);
        push_line(mk_line(16'hB2), 2);
        a0 = acc_cnt;
        WI_ready = 1'b1;
        for (int i = 0; i < 50 && acc_cnt - a0 < 3; i++) begin
            @(posedge clk); #1;
        end
        WI_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({MRA_resp_ready, WI_valid, FIFO_rd_en, wl_done, resp_overflow} !== 5'b0 || WI_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%b data=%h required all 0",
                     {MRA_resp_ready, WI_valid, FIFO_rd_en, wl_done, resp_overflow}, WI_data);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start(2);
        @(negedge clk);
        checks++;
        if (WI_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale got valid=%b required=0", WI_valid);
        end
        @(posedge clk); #1;
        WI_ready = 1'b1;
        push_line(mk_line(16'hC2), 2);
        wait_done("midreset");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_pending got=%0d required=0", exp_q.size());
        end
    endtask

`ifdef WI_STALL_CNT_EN
    task automatic test_stall_count;
        WI_ready = 1'b0;
        start(2);
        push_line(mk_line(16'hD3), 2);
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_cycles !== 32'd7) begin
            errors++;
            $display("FAIL stall_count got=%0d required=7", stall_cycles);
        end
        // One more stalled edge passes before the consumer becomes ready.
        @(posedge clk); #1;
        WI_ready = 1'b1;
        wait_done("stall");
        checks++;
        if (stall_cycles !== 32'd8) begin
            errors++;
            $display("FAIL stall_final got=%0d required=8", stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_even_list;
        test_odd_list;
        test_overflow;
        test_zero_len;
        test_mid_reset;
`ifdef WI_STALL_CNT_EN
        test_stall_count;
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
